// File: rtl/id_ex_issue_ctrl_pkg.sv
// Shared definitions for the ID/EX issue controller.
// Contents: FSM state encoding, default register-index width, the
// enable/flush/bubble control word driven by the controller, and the
// all-zero WB/M/EX control pattern used when a bubble enters ID/EX.
package id_ex_issue_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Front-end/ID-EX control word, MSB first:
  // PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } issue_ctl_t;

  localparam issue_ctl_t CTL_ISSUE  = 4'b1100;
  localparam issue_ctl_t CTL_BUBBLE = 4'b0001;
  localparam issue_ctl_t CTL_FLUSH  = 4'b1111;

  // WB/M/EX control the datapath writes into ID/EX while ID_EX_Bubble is high.
  localparam logic [7:0] ID_EX_CTRL_NOP = 8'h00;

endpackage

// File: rtl/id_ex_issue_ctrl_if.sv
// Decode-side bundle between the decode stage and the ID/EX issue controller.
// master: decode stage (drives instruction info, receives enables/counters)
// slave : id_ex_issue_ctrl
interface id_ex_issue_ctrl_if
  import id_ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();

  logic                  IFID_Valid;
  logic [REG_ADDR_W-1:0] IFID_RS1;
  logic [REG_ADDR_W-1:0] IFID_RS2;
  logic                  IFID_UsesRS2;
  logic [REG_ADDR_W-1:0] Dec_RD;
  logic                  Dec_MemRead;
  logic                  Branch_Taken;

  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Bubble;
  logic [31:0]           Stall_Cnt_Total;
  logic [31:0]           Flush_Cnt_Total;

  modport master (
    output IFID_Valid, IFID_RS1, IFID_RS2, IFID_UsesRS2, Dec_RD, Dec_MemRead, Branch_Taken,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Cnt_Total, Flush_Cnt_Total
  );

  modport slave (
    input  IFID_Valid, IFID_RS1, IFID_RS2, IFID_UsesRS2, Dec_RD, Dec_MemRead, Branch_Taken,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Cnt_Total, Flush_Cnt_Total
  );

endinterface

// File: rtl/id_ex_issue_ctrl_hazard_cmp.sv
// Load-use hazard comparator.
// Inputs : mirror of the instruction in ID/EX (valid, rd, is-load) and the
//          decoding instruction (valid, rs1, rs2, uses-rs2).
// Output : hazard - decoding instruction needs a load result not yet available.
module id_ex_issue_ctrl_hazard_cmp
  import id_ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ifid_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs2,
  output logic                  hazard
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign rd_nonzero = |ex_rd;
  assign rs1_hit    = (ex_rd == rs1);
  assign rs2_hit    = uses_rs2 & (ex_rd == rs2);
  assign hazard     = ex_valid & ex_memread & rd_nonzero & ifid_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_issue_ctrl.sv
// ID/EX write-side issue controller.
// Decides each cycle between issuing the decoded instruction, inserting a
// load-use bubble (front end held), or flushing the front end on a taken
// branch. A mirror of the last instruction issued into ID/EX feeds hazard
// detection so ID/EX outputs are never read back.
// Ports: clk, reset (async, active-low), bus (id_ex_issue_ctrl_if.slave).
// Optional build macro HAZARD_PERF_CNT_EN: saturating stall/flush counters;
// when undefined both counter outputs are tied to zero.
//
// state | meaning
// RUN   | normal issue; may flush or insert the first load-use bubble
// STALL | additional bubbles for slow data memory, cnt counts down to 1
module id_ex_issue_ctrl
  import id_ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  id_ex_issue_ctrl_if.slave   bus
);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  ex_valid, ex_valid_nx;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rd_nx;
  logic                  ex_memread, ex_memread_nx;
  logic                  hazard;
  issue_ctl_t            ctl;

  id_ex_issue_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_cmp (
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .ifid_valid (bus.IFID_Valid),
    .rs1        (bus.IFID_RS1),
    .rs2        (bus.IFID_RS2),
    .uses_rs2   (bus.IFID_UsesRS2),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      cnt        <= '0;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_memread <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ex_valid   <= ex_valid_nx;
      ex_rd      <= ex_rd_nx;
      ex_memread <= ex_memread_nx;
    end
  end

  // Any bubble or flush clears ex_valid so a bubbled load cannot stall twice.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ex_valid_nx   = ex_valid;
    ex_rd_nx      = ex_rd;
    ex_memread_nx = ex_memread;
    ctl           = CTL_ISSUE;
    unique case (state)
      ST_RUN: begin
        if (bus.Branch_Taken) begin
          ctl         = CTL_FLUSH;
          ex_valid_nx = 1'b0;
        end else if (hazard) begin
          ctl         = CTL_BUBBLE;
          ex_valid_nx = 1'b0;
          if (STALL_CYCLES > 1) begin
            state_nx = ST_STALL;
            cnt_nx   = CNT_W'(STALL_CYCLES - 1);
          end
        end else begin
          ex_valid_nx   = bus.IFID_Valid;
          ex_rd_nx      = bus.Dec_RD;
          ex_memread_nx = bus.Dec_MemRead;
        end
      end
      ST_STALL: begin
        ex_valid_nx = 1'b0;
        if (bus.Branch_Taken) begin
          ctl      = CTL_FLUSH;
          cnt_nx   = '0;
          state_nx = ST_RUN;
        end else begin
          ctl    = CTL_BUBBLE;
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  assign bus.PC_Write     = ctl.pc_write;
  assign bus.IF_ID_Write  = ctl.if_id_write;
  assign bus.IF_ID_Flush  = ctl.if_id_flush;
  assign bus.ID_EX_Bubble = ctl.id_ex_bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_tot;
  logic [31:0] flush_tot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_tot <= '0;
      flush_tot <= '0;
    end else begin
      if (ctl.id_ex_bubble && !ctl.if_id_flush && (stall_tot != '1))
        stall_tot <= stall_tot + 32'd1;
      if (ctl.if_id_flush && (flush_tot != '1))
        flush_tot <= flush_tot + 32'd1;
    end
  end

  assign bus.Stall_Cnt_Total = stall_tot;
  assign bus.Flush_Cnt_Total = flush_tot;
`else
  assign bus.Stall_Cnt_Total = '0;
  assign bus.Flush_Cnt_Total = '0;
`endif

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// Testbench for id_ex_issue_ctrl: two instances (STALL_CYCLES=1 and 3) share
// one stimulus stream. A reference model of the pipeline's issue behaviour
// pushes the expected control word and counter values per cycle; a monitor
// pops and compares on the falling edge.
module tb_id_ex_issue_ctrl;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  id_ex_issue_ctrl_if #(.REG_ADDR_W(5)) if1 ();
  id_ex_issue_ctrl_if #(.REG_ADDR_W(5)) if3 ();

  id_ex_issue_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  id_ex_issue_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: last issued instruction and bubbles still owed.
  bit          m_v   [2];
  logic [4:0]  m_rd  [2];
  bit          m_ld  [2];
  int          m_rem [2];
  int unsigned m_st  [2];
  int unsigned m_fl  [2];
  exp_t        q0[$];
  exp_t        q1[$];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut_sc%0d: got %h expected %h at %0t", name, (k == 0) ? 1 : 3, act, exp, $time);
    end
  endtask

  task automatic model(input int k, input bit rst, input bit v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                       input bit ld, input bit br);
    int   sc;
    bit   dep;
    exp_t e;
    sc = (k == 0) ? 1 : 3;
    if (!rst) begin
      m_v[k] = 0; m_rd[k] = '0; m_ld[k] = 0; m_rem[k] = 0; m_st[k] = 0; m_fl[k] = 0;
    end
    dep = m_v[k] && m_ld[k] && (m_rd[k] != 5'd0) && v &&
          ((m_rd[k] == rs1) || (u2 && (m_rd[k] == rs2)));
`ifdef HAZARD_PERF_CNT_EN
    e.st = m_st[k];
    e.fl = m_fl[k];
`else
    e.st = '0;
    e.fl = '0;
`endif
    if (br)               e.ctl = 4'b1111;
    else if (m_rem[k] > 0) e.ctl = 4'b0001;
    else if (dep)          e.ctl = 4'b0001;
    else                   e.ctl = 4'b1100;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (rst) begin
      if (br) begin
        m_v[k] = 0; m_rem[k] = 0; m_fl[k]++;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--; m_st[k]++;
      end else if (dep) begin
        m_v[k] = 0; m_rem[k] = sc - 1; m_st[k]++;
      end else begin
        m_v[k] = v; m_rd[k] = rd; m_ld[k] = ld;
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u2, input logic [4:0] rd, input bit ld, input bit br);
    @(posedge clk);
    #1;
    reset = rst;
    if1.IFID_Valid = v;  if1.IFID_RS1 = rs1; if1.IFID_RS2 = rs2; if1.IFID_UsesRS2 = u2;
    if1.Dec_RD = rd;     if1.Dec_MemRead = ld; if1.Branch_Taken = br;
    if3.IFID_Valid = v;  if3.IFID_RS1 = rs1; if3.IFID_RS2 = rs2; if3.IFID_UsesRS2 = u2;
    if3.Dec_RD = rd;     if3.Dec_MemRead = ld; if3.Branch_Taken = br;
    for (int k = 0; k < 2; k++) model(k, rst, v, rs1, rs2, u2, rd, ld, br);
  endtask

  // Monitor: one expected entry per DUT per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("ctl", 0, {28'd0, if1.PC_Write, if1.IF_ID_Write, if1.IF_ID_Flush, if1.ID_EX_Bubble}, {28'd0, e.ctl});
        chk("stall_cnt", 0, if1.Stall_Cnt_Total, e.st);
        chk("flush_cnt", 0, if1.Flush_Cnt_Total, e.fl);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("ctl", 1, {28'd0, if3.PC_Write, if3.IF_ID_Write, if3.IF_ID_Flush, if3.ID_EX_Bubble}, {28'd0, e.ctl});
        chk("stall_cnt", 1, if3.Stall_Cnt_Total, e.st);
        chk("flush_cnt", 1, if3.Flush_Cnt_Total, e.fl);
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    if1.IFID_Valid = 0; if1.IFID_RS1 = 0; if1.IFID_RS2 = 0; if1.IFID_UsesRS2 = 0;
    if1.Dec_RD = 0; if1.Dec_MemRead = 0; if1.Branch_Taken = 0;
    if3.IFID_Valid = 0; if3.IFID_RS1 = 0; if3.IFID_RS2 = 0; if3.IFID_UsesRS2 = 0;
    if3.Dec_RD = 0; if3.Dec_MemRead = 0; if3.Branch_Taken = 0;

    // reset held for 3 cycles
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // load-use on rs1: lw x5 ; add x6, x5, x3 held while stalled
    step(1, 1, 5'd1, 5'd2, 1, 5'd5, 1, 0);
    repeat (4) step(1, 1, 5'd5, 5'd3, 1, 5'd6, 0, 0);

    // no-stall cases: lw x0 ; rs1=x0
    step(1, 1, 5'd1, 5'd2, 0, 5'd0, 1, 0);
    step(1, 1, 5'd0, 5'd0, 1, 5'd8, 0, 0);
    // add x5 ; rs1=x5 (forwarded)
    step(1, 1, 5'd1, 5'd2, 1, 5'd5, 0, 0);
    step(1, 1, 5'd5, 5'd2, 1, 5'd8, 0, 0);
    // lw x5 ; rs2=x5 but rs2 unused
    step(1, 1, 5'd1, 5'd2, 1, 5'd5, 1, 0);
    step(1, 1, 5'd3, 5'd5, 0, 5'd8, 0, 0);
    // lw x5 ; dependent slot not valid
    step(1, 1, 5'd1, 5'd2, 1, 5'd5, 1, 0);
    step(1, 0, 5'd5, 5'd5, 1, 5'd8, 0, 0);
    step(1, 1, 5'd5, 5'd5, 1, 5'd8, 0, 0);

    // lw x7 ; sw with rs2=x7
    step(1, 1, 5'd1, 5'd2, 1, 5'd7, 1, 0);
    repeat (4) step(1, 1, 5'd2, 5'd7, 1, 5'd0, 0, 0);

    // branch aborts stall in the 2nd bubble cycle
    step(1, 1, 5'd1, 5'd2, 1, 5'd7, 1, 0);
    step(1, 1, 5'd7, 5'd2, 1, 5'd9, 0, 0);
    step(1, 1, 5'd7, 5'd2, 1, 5'd9, 0, 1);
    repeat (3) step(1, 1, 5'd7, 5'd2, 1, 5'd9, 0, 0);

    // branch and hazard in the same RUN cycle
    step(1, 1, 5'd1, 5'd2, 1, 5'd9, 1, 0);
    step(1, 1, 5'd9, 5'd2, 1, 5'd4, 0, 1);
    repeat (2) step(1, 1, 5'd9, 5'd2, 1, 5'd4, 0, 0);

    // reset asserted mid-stall
    step(1, 1, 5'd1, 5'd2, 1, 5'd7, 1, 0);
    step(1, 1, 5'd7, 5'd2, 1, 5'd9, 0, 0);
    step(0, 1, 5'd7, 5'd2, 1, 5'd9, 0, 0);
    repeat (2) step(1, 1, 5'd7, 5'd2, 1, 5'd9, 0, 0);

    // randomized traffic with a small register range to make hazards frequent
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end

    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("queue_drain", 0, 32'(q0.size()), 32'd0);
    chk("queue_drain", 1, 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
